// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU instruction sequencer: step states, opcodes,
// one-hot ALU operation bit positions and instruction field positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  localparam logic [4:0] OPC_ADD  = 5'b00000;
  localparam logic [4:0] OPC_SUB  = 5'b00001;
  localparam logic [4:0] OPC_AND  = 5'b00010;
  localparam logic [4:0] OPC_OR   = 5'b00011;
  localparam logic [4:0] OPC_SHR  = 5'b00101;
  localparam logic [4:0] OPC_SHRA = 5'b00110;
  localparam logic [4:0] OPC_SHL  = 5'b00111;
  localparam logic [4:0] OPC_ROR  = 5'b01000;
  localparam logic [4:0] OPC_ROL  = 5'b01001;
  localparam logic [4:0] OPC_NEG  = 5'b01010;
  localparam logic [4:0] OPC_NOT  = 5'b01011;
  localparam logic [4:0] OPC_MUL  = 5'b01100;
  localparam logic [4:0] OPC_DIV  = 5'b01101;

  localparam int ALU_OP_W = 13;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

endpackage

// File: rtl/alu_instr_sequencer_reg_field_decode.sv
// 4-to-16 one-hot decoder with enable; turns an R field into register strobes.
module reg_field_decode (
  input  logic        en,
  input  logic [3:0]  field,
  output logic [15:0] onehot
);

  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    assign onehot[gi] = en && (field == 4'(gi));
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control unit stepping the single-bus datapath through fetch (T0..T2)
// and execute (T3..T6) of register-register ALU instructions.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_rdy,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                MDMuxread,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zlowin,
  output logic                Zhighin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [15:0]         Rin,
  output logic [15:0]         Rout,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                done,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       ir_unused;

  assign opc       = ir[OPC_LSB +: 5];
  assign ra        = ir[RA_LSB +: 4];
  assign rb        = ir[RB_LSB +: 4];
  assign rc        = ir[RC_LSB +: 4];
  assign ir_unused = ^ir[RC_LSB-1:0];

  logic       op_legal, is_muldiv, is_unary;
  logic [3:0] op_idx;

  always_comb begin
    op_legal  = 1'b1;
    is_muldiv = 1'b0;
    is_unary  = 1'b0;
    op_idx    = OP_ADD;
    case (opc)
      OPC_ADD:  op_idx = OP_ADD;
      OPC_SUB:  op_idx = OP_SUB;
      OPC_AND:  op_idx = OP_AND;
      OPC_OR:   op_idx = OP_OR;
      OPC_SHR:  op_idx = OP_SHR;
      OPC_SHRA: op_idx = OP_SHRA;
      OPC_SHL:  op_idx = OP_SHL;
      OPC_ROR:  op_idx = OP_ROR;
      OPC_ROL:  op_idx = OP_ROL;
      OPC_NEG:  begin op_idx = OP_NEG; is_unary = 1'b1; end
      OPC_NOT:  begin op_idx = OP_NOT; is_unary = 1'b1; end
      OPC_MUL:  begin op_idx = OP_MUL; is_muldiv = 1'b1; end
      OPC_DIV:  begin op_idx = OP_DIV; is_muldiv = 1'b1; end
      default:  op_legal = 1'b0;
    endcase
  end

  logic final_step;
  assign final_step = ((state_reg == S_T5) && !is_muldiv) || (state_reg == S_T6);

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (final_step)
        count_reg <= count_reg + CNT_W'(1);
    end
  end

  logic       rout_en, rin_en;
  logic [3:0] rout_sel;

  always_comb begin
    state_next = state_reg;
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0;
    MDMuxread = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zlowin = 1'b0; Zhighin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; done = 1'b0; illegal = 1'b0;
    rout_en = 1'b0; rout_sel = rb; rin_en = 1'b0;
    case (state_reg)
      S_IDLE: if (run) state_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        // Held for every wait cycle; reloading PC and MDR is harmless.
        Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1; MDRin = 1'b1;
        if (mem_rdy) state_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        rout_en = 1'b1; Yin = 1'b1;
        if (op_legal) state_next = S_T4;
        else begin
          illegal    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_T4: begin
        rout_en  = 1'b1;
        rout_sel = is_unary ? rb : rc;
        Zlowin   = 1'b1;
        Zhighin  = is_muldiv;
        state_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin       = 1'b1;
          state_next = S_T6;
        end else begin
          rin_en     = 1'b1;
          done       = 1'b1;
          state_next = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
        state_next = run ? S_T0 : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < ALU_OP_W; gi++) begin : g_alu_op
    assign alu_op[gi] = (state_reg == S_T4) && op_legal && (op_idx == 4'(gi));
  end

  reg_field_decode u_rout_dec (
    .en     (rout_en),
    .field  (rout_sel),
    .onehot (Rout)
  );

  reg_field_decode u_rin_dec (
    .en     (rin_en),
    .field  (ra),
    .onehot (Rin)
  );

  assign instr_count = count_reg;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed self-checking bench for alu_instr_sequencer: fetch/execute sequences,
// memory wait, MUL, illegal opcode, mid-instruction clear and run release.
module tb_alu_instr_sequencer;

  logic        clock = 1'b0;
  logic        clear, run, mem_rdy;
  logic [31:0] ir;
  logic        PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, done, illegal;
  logic [15:0] Rin, Rout;
  logic [12:0] alu_op;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;

  localparam logic [16:0] K_PCOUT    = 17'h10000;
  localparam logic [16:0] K_MARIN    = 17'h08000;
  localparam logic [16:0] K_INCPC    = 17'h04000;
  localparam logic [16:0] K_PCIN     = 17'h02000;
  localparam logic [16:0] K_MDMUX    = 17'h01000;
  localparam logic [16:0] K_MDRIN    = 17'h00800;
  localparam logic [16:0] K_MDROUT   = 17'h00400;
  localparam logic [16:0] K_IRIN     = 17'h00200;
  localparam logic [16:0] K_YIN      = 17'h00100;
  localparam logic [16:0] K_ZLOWIN   = 17'h00080;
  localparam logic [16:0] K_ZHIGHIN  = 17'h00040;
  localparam logic [16:0] K_ZLOWOUT  = 17'h00020;
  localparam logic [16:0] K_ZHIGHOUT = 17'h00010;
  localparam logic [16:0] K_HIIN     = 17'h00008;
  localparam logic [16:0] K_LOIN     = 17'h00004;
  localparam logic [16:0] K_DONE     = 17'h00002;
  localparam logic [16:0] K_ILL      = 17'h00001;

  localparam logic [16:0] E_T0 = K_PCOUT | K_MARIN | K_INCPC | K_ZLOWIN;
  localparam logic [16:0] E_T1 = K_ZLOWOUT | K_PCIN | K_MDMUX | K_MDRIN;
  localparam logic [16:0] E_T2 = K_MDROUT | K_IRIN;

  localparam logic [31:0] IR_SHR = 32'h2891_8000;
  localparam logic [31:0] IR_MUL = 32'h6122_8000;
  localparam logic [31:0] IR_ADD = 32'h0091_8000;
  localparam logic [31:0] IR_ILL = 32'hF800_0000;

  logic [16:0] ctl;
  logic [61:0] obs;
  assign ctl = {PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin,
                Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, done, illegal};
  assign obs = {ctl, Rin, Rout, alu_op};

  alu_instr_sequencer #(.CNT_W(16)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
    .MDMuxread(MDMuxread), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
    .done(done), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; run = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    ir = 32'h0; mem_rdy = 1'b0;
    do_clear();
    checks++;
    if (obs !== 62'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    checks++;
    if (instr_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", instr_count);
    end
    $display("test_reset: outputs=%h count=%0d", obs, instr_count);
  endtask

  task automatic test_shr();
    ir = IR_SHR; mem_rdy = 1'b1;
    do_clear();
    run = 1'b1;
    tick();
    checks++;
    if (obs !== {E_T0, 16'h0, 16'h0, 13'h0}) begin
      errors++; $display("FAIL shr_t0: got %h want %h", obs, {E_T0, 16'h0, 16'h0, 13'h0});
    end
    tick();
    checks++;
    if (obs !== {E_T1, 16'h0, 16'h0, 13'h0}) begin
      errors++; $display("FAIL shr_t1: got %h want %h", obs, {E_T1, 16'h0, 16'h0, 13'h0});
    end
    tick();
    checks++;
    if (obs !== {E_T2, 16'h0, 16'h0, 13'h0}) begin
      errors++; $display("FAIL shr_t2: got %h want %h", obs, {E_T2, 16'h0, 16'h0, 13'h0});
    end
    tick();
    checks++;
    if (obs !== {K_YIN, 16'h0, 16'h0004, 13'h0}) begin
      errors++; $display("FAIL shr_t3: got %h want %h", obs, {K_YIN, 16'h0, 16'h0004, 13'h0});
    end
    tick();
    checks++;
    if (obs !== {K_ZLOWIN, 16'h0, 16'h0008, 13'h0040}) begin
      errors++; $display("FAIL shr_t4: got %h want %h", obs, {K_ZLOWIN, 16'h0, 16'h0008, 13'h0040});
    end
    tick();
    checks++;
    if (obs !== {K_ZLOWOUT | K_DONE, 16'h0002, 16'h0, 13'h0}) begin
      errors++; $display("FAIL shr_t5: got %h want %h", obs, {K_ZLOWOUT | K_DONE, 16'h0002, 16'h0, 13'h0});
    end
    tick();
    checks++;
    if (obs !== {E_T0, 16'h0, 16'h0, 13'h0}) begin
      errors++; $display("FAIL shr_back_to_back_t0: got %h want %h", obs, {E_T0, 16'h0, 16'h0, 13'h0});
    end
    checks++;
    if (instr_count !== 16'd1) begin
      errors++; $display("FAIL shr_count: got %0d want 1", instr_count);
    end
    $display("test_shr: count=%0d", instr_count);
  endtask

  task automatic test_mem_wait();
    int n;
    ir = IR_SHR; mem_rdy = 1'b0;
    do_clear();
    run = 1'b1;
    tick();
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); n++;
      checks++;
      if (obs !== {E_T1, 16'h0, 16'h0, 13'h0}) begin
        errors++; $display("FAIL wait_t1_hold%0d: got %h want %h", k, obs, {E_T1, 16'h0, 16'h0, 13'h0});
      end
    end
    mem_rdy = 1'b1;
    for (int k = 0; k < 20 && done !== 1'b1; k++) begin
      tick(); n++;
    end
    checks++;
    if (n !== 8 || done !== 1'b1) begin
      errors++; $display("FAIL wait_done_latency: got %0d cycles done=%b want 8 done=1", n, done);
    end
    run = 1'b0;
    tick();
    checks++;
    if (obs !== 62'h0 || instr_count !== 16'd1) begin
      errors++; $display("FAIL wait_idle: got %h count=%0d want 0 count=1", obs, instr_count);
    end
    $display("test_mem_wait: done after %0d cycles", n);
  endtask

  task automatic test_mul();
    ir = IR_MUL; mem_rdy = 1'b1;
    do_clear();
    run = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if (obs !== {K_YIN, 16'h0, 16'h0010, 13'h0}) begin
      errors++; $display("FAIL mul_t3: got %h want %h", obs, {K_YIN, 16'h0, 16'h0010, 13'h0});
    end
    tick();
    checks++;
    if (obs !== {K_ZLOWIN | K_ZHIGHIN, 16'h0, 16'h0020, 13'h0004}) begin
      errors++; $display("FAIL mul_t4: got %h want %h", obs, {K_ZLOWIN | K_ZHIGHIN, 16'h0, 16'h0020, 13'h0004});
    end
    tick();
    checks++;
    if (obs !== {K_ZLOWOUT | K_LOIN, 16'h0, 16'h0, 13'h0}) begin
      errors++; $display("FAIL mul_t5: got %h want %h", obs, {K_ZLOWOUT | K_LOIN, 16'h0, 16'h0, 13'h0});
    end
    run = 1'b0;
    tick();
    checks++;
    if (obs !== {K_ZHIGHOUT | K_HIIN | K_DONE, 16'h0, 16'h0, 13'h0}) begin
      errors++; $display("FAIL mul_t6: got %h want %h", obs, {K_ZHIGHOUT | K_HIIN | K_DONE, 16'h0, 16'h0, 13'h0});
    end
    tick();
    checks++;
    if (obs !== 62'h0 || instr_count !== 16'd1) begin
      errors++; $display("FAIL mul_idle: got %h count=%0d want 0 count=1", obs, instr_count);
    end
    $display("test_mul: count=%0d", instr_count);
  endtask

  task automatic test_illegal();
    ir = IR_ILL; mem_rdy = 1'b1;
    do_clear();
    run = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if (obs !== {K_YIN | K_ILL, 16'h0, 16'h0001, 13'h0}) begin
      errors++; $display("FAIL illegal_t3: got %h want %h", obs, {K_YIN | K_ILL, 16'h0, 16'h0001, 13'h0});
    end
    tick();
    checks++;
    if (obs !== 62'h0 || instr_count !== 16'd0) begin
      errors++; $display("FAIL illegal_idle: got %h count=%0d want 0 count=0", obs, instr_count);
    end
    run = 1'b0;
    $display("test_illegal: count=%0d", instr_count);
  endtask

  task automatic test_clear_mid();
    ir = IR_ADD; mem_rdy = 1'b1;
    do_clear();
    run = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (obs !== {K_ZLOWOUT | K_DONE, 16'h0002, 16'h0, 13'h0}) begin
      errors++; $display("FAIL add_t5: got %h want %h", obs, {K_ZLOWOUT | K_DONE, 16'h0002, 16'h0, 13'h0});
    end
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (obs !== {K_ZLOWIN, 16'h0, 16'h0008, 13'h0001} || instr_count !== 16'd1) begin
      errors++; $display("FAIL add_t4: got %h count=%0d want %h count=1", obs, instr_count, {K_ZLOWIN, 16'h0, 16'h0008, 13'h0001});
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; run = 1'b0;
    checks++;
    if (obs !== 62'h0 || instr_count !== 16'd0) begin
      errors++; $display("FAIL clear_mid: got %h count=%0d want 0 count=0", obs, instr_count);
    end
    tick();
    checks++;
    if (obs !== 62'h0) begin
      errors++; $display("FAIL clear_stays_idle: got %h want 0", obs);
    end
    $display("test_clear_mid: count=%0d", instr_count);
  endtask

  task automatic test_run_drop();
    ir = IR_ADD; mem_rdy = 1'b1;
    do_clear();
    run = 1'b1;
    tick(); tick(); tick();
    run = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (obs !== {K_ZLOWOUT | K_DONE, 16'h0002, 16'h0, 13'h0}) begin
      errors++; $display("FAIL rundrop_t5: got %h want %h", obs, {K_ZLOWOUT | K_DONE, 16'h0002, 16'h0, 13'h0});
    end
    tick();
    checks++;
    if (obs !== 62'h0 || instr_count !== 16'd1) begin
      errors++; $display("FAIL rundrop_idle: got %h count=%0d want 0 count=1", obs, instr_count);
    end
    tick();
    checks++;
    if (obs !== 62'h0) begin
      errors++; $display("FAIL rundrop_stays_idle: got %h want 0", obs);
    end
    $display("test_run_drop: count=%0d", instr_count);
  endtask

  initial begin
    clear = 1'b0; run = 1'b0; mem_rdy = 1'b0; ir = 32'h0;
    test_reset();
    test_shr();
    test_mem_wait();
    test_mul();
    test_illegal();
    test_clear_mid();
    test_run_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
